sseg_scan_decoder: RTL and testbench

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

---
 rtl/sseg_scan_decoder_pkg.sv | 38 +++
 rtl/sseg_glyph_decode.sv | 30 +++
 rtl/sseg_scan_decoder.sv | 165 ++++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_decoder_pkg.sv
`default_nettype none
// =============================================================================
// Module   : sseg_scan_decoder_pkg
// Purpose  : Shared FSM state type and 7-segment glyph table (active-low, g..a)
// Revision : 1.0 - initial release
// =============================================================================
package sseg_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    localparam logic [6:0] c_blank = 7'b1111111;

    localparam logic [6:0] c_glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Anode enables are active-low; these look at the set of driven digits.
    function automatic logic one_low(input logic [3:0] i_an);
        logic [3:0] w_low;
        w_low = ~i_an;
        return (w_low != 4'h0) && ((w_low & (w_low - 4'h1)) == 4'h0);
    endfunction

    function automatic logic multi_low(input logic [3:0] i_an);
        logic [3:0] w_low;
        w_low = ~i_an;
        return (w_low & (w_low - 4'h1)) != 4'h0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_glyph_decode.sv
`default_nettype none
// =============================================================================
// Module   : sseg_glyph_decode
// Purpose  : Combinational 7-segment pattern to hex nibble / blank classifier
// Revision : 1.0 - initial release
// =============================================================================
module sseg_glyph_decode
    import sseg_scan_decoder_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_valid,
    output logic       o_blank
);

    always_comb begin
        o_nibble = 4'h0;
        o_valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i_pattern == c_glyph[i]) begin
                o_nibble = 4'(i);
                o_valid  = 1'b1;
            end
        end
    end

    assign o_blank = (i_pattern == c_blank);

endmodule
`default_nettype wire

// File: rtl/sseg_scan_decoder.sv
`default_nettype none
// =============================================================================
// Module   : sseg_scan_decoder
// Purpose  : Recovers per-digit hex values from a multiplexed 7-segment bus
// Revision : 1.0 - initial release
// =============================================================================
module sseg_scan_decoder
    import sseg_scan_decoder_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int FRAME_TMO  = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dig_valid,
    output logic [3:0]  dig_blank,
    output logic [3:0]  dp_seen,
    output logic        frame_done,
    output logic        err
);

    localparam int                 c_tmo_w  = $clog2(FRAME_TMO + 1);
    localparam logic [7:0]         c_settle = 8'(SETTLE_CYC);
    localparam logic [c_tmo_w-1:0] c_tmo    = c_tmo_w'(FRAME_TMO);

    state_t              r_state;
    state_t              w_next;
    logic [11:0]         r_prev;
    logic [7:0]          r_cnt;
    logic                r_done;
    logic [c_tmo_w-1:0]  r_tmo;
    logic [3:0]          r_mask;
    logic [15:0]         r_digits;
    logic [3:0]          r_valid;
    logic [3:0]          r_blank;
    logic [3:0]          r_dp;
    logic                r_frame_done;
    logic                r_err;

    logic [11:0]         w_smp;
    logic                w_chg;
    logic                w_win;
    logic                w_accept;
    logic                w_multi;
    logic                w_tmo_hit;
    logic [3:0]          w_sel;
    logic [3:0]          w_mask_nxt;
    logic [3:0]          w_dec_nibble;
    logic                w_dec_valid;
    logic                w_dec_blank;

    assign w_smp = {an, sseg, dp};
    assign w_chg = (w_smp != r_prev);
    // r_done keeps a window that outlives the counter target from firing twice.
    assign w_win = (r_cnt == c_settle) && !r_done;

    // The accepted sample is the registered stable value, not the live bus.
    sseg_glyph_decode u_glyph (
        .i_pattern (r_prev[7:1]),
        .o_nibble  (w_dec_nibble),
        .o_valid   (w_dec_valid),
        .o_blank   (w_dec_blank)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (one_low(an)) w_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_chg)      w_next = one_low(an) ? ST_SETTLE : ST_IDLE;
                else if (w_win) w_next = ST_HELD;
            end
            ST_HELD: begin
                if (w_chg)      w_next = one_low(an) ? ST_SETTLE : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_state == ST_SETTLE) && w_win;
        w_multi  = w_win && multi_low(r_prev[11:8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 12'h000;
            r_cnt  <= 8'h00;
            r_done <= 1'b0;
        end else begin
            r_prev <= w_smp;
            if (w_chg) begin
                r_cnt  <= 8'h01;
                r_done <= 1'b0;
            end else begin
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'h01;
                if (w_win)          r_done <= 1'b1;
            end
        end
    end

    assign w_sel      = ~r_prev[11:8];
    assign w_tmo_hit  = (r_tmo == c_tmo);
    assign w_mask_nxt = (w_tmo_hit ? 4'h0 : r_mask) | w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo        <= '0;
            r_mask       <= 4'h0;
            r_digits     <= 16'h0000;
            r_valid      <= 4'h0;
            r_blank      <= 4'hF;
            r_dp         <= 4'h0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_err        <= w_multi;
            if (w_tmo_hit) r_mask <= 4'h0;
            if (w_accept) begin
                r_tmo <= '0;
                for (int n = 0; n < 4; n++) begin
                    if (w_sel[n]) begin
                        if (w_dec_valid) r_digits[4*n +: 4] <= w_dec_nibble;
                        r_valid[n] <= w_dec_valid;
                        r_blank[n] <= w_dec_blank;
                        r_dp[n]    <= ~r_prev[0];
                    end
                end
                if (!w_dec_valid && !w_dec_blank) r_err <= 1'b1;
                if (w_mask_nxt == 4'hF) begin
                    r_mask       <= 4'h0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_mask <= w_mask_nxt;
                end
            end else if (!w_tmo_hit) begin
                r_tmo <= r_tmo + c_tmo_w'(1);
            end
        end
    end

    assign digits     = r_digits;
    assign dig_valid  = r_valid;
    assign dig_blank  = r_blank;
    assign dp_seen    = r_dp;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
`default_nettype none
// =============================================================================
// Module   : tb_sseg_scan_decoder
// Purpose  : Directed self-checking bench for sseg_scan_decoder
// Revision : 1.0 - initial release
// =============================================================================
module tb_sseg_scan_decoder;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  dig_valid;
    logic [3:0]  dig_blank;
    logic [3:0]  dp_seen;
    logic        frame_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int fd, er, fd_tot, er_tot;

    sseg_scan_decoder #(
        .SETTLE_CYC (16),
        .FRAME_TMO  (200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .sseg       (sseg),
        .dp         (dp),
        .digits     (digits),
        .dig_valid  (dig_valid),
        .dig_blank  (dig_blank),
        .dp_seen    (dp_seen),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bus value for n cycles, counting pulses seen after each edge.
    task automatic apply(input logic [3:0] a, input logic [6:0] s, input logic d,
                         input int n, output int fdc, output int erc);
        an   = a;
        sseg = s;
        dp   = d;
        fdc  = 0;
        erc  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            fdc += int'(frame_done);
            erc += int'(err);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_digits"}, digits, 16'h0000);
        check({tag, "_valid"},  dig_valid, 4'h0);
        check({tag, "_blank"},  dig_blank, 4'hF);
        check({tag, "_dp"},     dp_seen, 4'h0);
        check({tag, "_fd"},     frame_done, 1'b0);
        check({tag, "_err"},    err, 1'b0);
    endtask

    logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] scan_g  [4] = '{G1, G2, G3, G4};

    initial begin
        rst  = 1'b1;
        an   = 4'hF;
        sseg = BL;
        dp   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;

        // Single digit: output lands exactly on the 17th edge
        apply(4'b1110, G3, 1'b1, 16, fd, er);
        check("t1_early_valid", dig_valid[0], 1'b0);
        apply(4'b1110, G3, 1'b1, 1, fd, er);
        check("t1_valid", dig_valid[0], 1'b1);
        check("t1_nibble", digits[3:0], 4'h3);
        apply(4'b1110, G3, 1'b1, 3, fd, er);
        check("t1_err_none", err, 1'b0);

        // Full scan, digit 0 overwritten; frame completes on digit 3
        for (int d = 0; d < 4; d++) begin
            apply(scan_an[d], scan_g[d], 1'b1, 16, fd, er);
            check("t2_fd_pre", fd, 0);
            apply(scan_an[d], scan_g[d], 1'b1, 1, fd, er);
            check("t2_fd_at", frame_done, (d == 3) ? 1'b1 : 1'b0);
            apply(scan_an[d], scan_g[d], 1'b1, 3, fd, er);
            check("t2_fd_post", fd, 0);
        end
        check("t2_digits", digits, 16'h4321);
        check("t2_valid", dig_valid, 4'hF);

        // Two anodes low: single err pulse, nothing else moves
        apply(4'b1100, G7, 1'b1, 16, fd, er);
        check("t3_err_pre", er, 0);
        apply(4'b1100, G7, 1'b1, 1, fd, er);
        check("t3_err_at", err, 1'b1);
        apply(4'b1100, G7, 1'b1, 3, fd, er);
        check("t3_err_post", er, 0);
        check("t3_digits", digits, 16'h4321);
        check("t3_valid", dig_valid, 4'hF);

        // Bus never stable long enough, then blank held on digit 2
        fd_tot = 0;
        er_tot = 0;
        for (int k = 0; k < 6; k++) begin
            apply(4'b1011, k[0] ? G6 : G5, 1'b1, 8, fd, er);
            fd_tot += fd;
            er_tot += er;
        end
        check("t4_toggle_err", er_tot, 0);
        check("t4_toggle_fd", fd_tot, 0);
        check("t4_toggle_digits", digits, 16'h4321);
        check("t4_toggle_valid", dig_valid, 4'hF);
        apply(4'b1011, BL, 1'b1, 20, fd, er);
        check("t4_blank", dig_blank, 4'b0100);
        check("t4_valid", dig_valid, 4'b1011);
        check("t4_digits", digits, 16'h4321);
        check("t4_err", er, 0);
        check("t4_fd", fd, 0);

        // Undecodable pattern with dp lit on digit 1
        apply(4'b1101, 7'b0101010, 1'b0, 20, fd, er);
        check("t5_err", er, 1);
        check("t5_fd", fd, 0);
        check("t5_valid", dig_valid, 4'b1001);
        check("t5_blank", dig_blank, 4'b0100);
        check("t5_dp", dp_seen, 4'b0010);
        check("t5_digits", digits, 16'h4321);

        // Mask now holds digits 1,2: digit 3 must not complete, digit 0 must
        apply(4'b0111, G9, 1'b1, 20, fd, er);
        check("t5_mask_d3", fd, 0);
        apply(4'b1110, G8, 1'b1, 20, fd, er);
        check("t5_mask_d0", fd, 1);
        check("t5_mask_digits", digits, 16'h9328);

        // Frame timeout clears a partial mask
        apply(4'b1110, G0, 1'b1, 20, fd, er);
        check("t6_fd_d0", fd, 0);
        apply(4'b1101, G1, 1'b1, 20, fd, er);
        check("t6_fd_d1", fd, 0);
        apply(4'b1011, G2, 1'b1, 20, fd, er);
        check("t6_fd_d2", fd, 0);
        apply(4'b1111, BL, 1'b1, 250, fd, er);
        apply(4'b0111, G3, 1'b1, 20, fd, er);
        check("t6_fd_after_tmo", fd, 0);
        check("t6_digits", digits, 16'h3210);
        apply(4'b1110, G4, 1'b1, 20, fd, er);
        apply(4'b1101, G5, 1'b1, 20, fd_tot, er);
        check("t6_fd_partial", fd + fd_tot, 0);
        apply(4'b1011, G6, 1'b1, 20, fd, er);
        check("t6_fd_complete", fd, 1);

        // Reset mid-window, then a full window is needed again
        apply(4'b1110, G5, 1'b1, 10, fd, er);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("rst1");
        rst = 1'b0;
        apply(4'b1110, G5, 1'b1, 16, fd, er);
        check("t7_early_valid", dig_valid[0], 1'b0);
        apply(4'b1110, G5, 1'b1, 1, fd, er);
        check("t7_valid", dig_valid[0], 1'b1);
        check("t7_digits", digits, 16'h0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
